// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and constants for the ALU request scheduler: FSM states,
// ALU command codes, legality limits and command-dependent latencies.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned ADD     = 0;
    localparam int unsigned SUB     = 1;
    localparam int unsigned ADD_CIN = 2;
    localparam int unsigned SUB_CIN = 3;
    localparam int unsigned CMP     = 8;
    localparam int unsigned INC_MUL = 9;
    localparam int unsigned SHL_SUB = 10;
    localparam int unsigned ROL     = 12;
    localparam int unsigned ROR     = 13;

    localparam int unsigned MAX_ARITH_CMD = 10;
    localparam int unsigned MAX_LOGIC_CMD = 13;

    localparam int unsigned LAT_STD = 2;
    localparam int unsigned LAT_MUL = 3;

    function automatic logic cmd_legal(input logic mode, input int unsigned cmd);
        return mode ? (cmd <= MAX_ARITH_CMD) : (cmd <= MAX_LOGIC_CMD);
    endfunction

    // Multiply-class arithmetic commands need one extra ALU edge.
    function automatic int unsigned op_latency(input logic mode, input int unsigned cmd);
        return (mode && (cmd == INC_MUL || cmd == SHL_SUB)) ? LAT_MUL : LAT_STD;
    endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning upward from a pointer,
// pointer moves to one past the winner when the grant is accepted.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    logic [IDW-1:0] ptr_reg;

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg <= '0;
        end else if (accept) begin
            ptr_reg <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Multi-client front-end for the shared ALU: round-robin request intake,
// single in-flight operation, latency-timed capture and tagged response.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CW   = 4,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_opa,
    input  logic [NREQ*DW-1:0] req_opb,
    input  logic [NREQ*CW-1:0] req_cmd,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW+1:0]     rsp_res,
    output logic              rsp_cout,
    output logic              rsp_oflow,
    output logic              rsp_g,
    output logic              rsp_e,
    output logic              rsp_l,
    output logic              rsp_err,
    output logic              busy,
    output logic              alu_rst,
    output logic              alu_ce,
    output logic [1:0]        alu_inp_valid,
    output logic [DW-1:0]     alu_opa,
    output logic [DW-1:0]     alu_opb,
    output logic [CW-1:0]     alu_cmd,
    output logic              alu_mode,
    output logic              alu_cin,
    input  logic [DW+1:0]     alu_res,
    input  logic              alu_cout,
    input  logic              alu_oflow,
    input  logic              alu_g,
    input  logic              alu_e,
    input  logic              alu_l,
    input  logic              alu_err
);

    state_t          state_reg;
    logic [2:0]      cnt_reg;
    logic [IDW-1:0]  id_reg;
    logic [DW-1:0]   opa_reg;
    logic [DW-1:0]   opb_reg;
    logic [CW-1:0]   cmd_reg;
    logic            mode_reg;
    logic            cin_reg;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic            accept;
    logic [CW-1:0]   sel_cmd;
    logic            sel_mode;
    logic            sel_legal;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req_valid),
        .accept      (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign accept    = (state_reg == IDLE) && grant_valid && !RST;
    assign req_ready = accept ? grant : '0;
    assign sel_cmd   = req_cmd[grant_idx*CW +: CW];
    assign sel_mode  = req_mode[grant_idx];
    assign sel_legal = cmd_legal(sel_mode, 32'(sel_cmd));

    assign busy    = (state_reg != IDLE);
    assign alu_rst = RST;
    assign alu_ce  = 1'b1;

    // Only a solid logic 1 on an ALU pin is captured as 1; x/z read as 0.
    logic [DW+1:0] res_clean;
    logic [5:0]    flag_pins;
    logic [5:0]    flag_clean;

    assign flag_pins = {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err};

    generate
        for (genvar gi = 0; gi < DW + 2; gi++) begin : g_res_clean
            assign res_clean[gi] = (alu_res[gi] === 1'b1);
        end
        for (genvar gi = 0; gi < 6; gi++) begin : g_flag_clean
            assign flag_clean[gi] = (flag_pins[gi] === 1'b1);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            id_reg        <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            cmd_reg       <= '0;
            mode_reg      <= 1'b0;
            cin_reg       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_res       <= '0;
            {rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err} <= '0;
            alu_inp_valid <= 2'b00;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_cmd       <= '0;
            alu_mode      <= 1'b0;
            alu_cin       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        id_reg   <= grant_idx;
                        opa_reg  <= req_opa[grant_idx*DW +: DW];
                        opb_reg  <= req_opb[grant_idx*DW +: DW];
                        cmd_reg  <= sel_cmd;
                        mode_reg <= sel_mode;
                        cin_reg  <= req_cin[grant_idx];
                        if (sel_legal) begin
                            state_reg <= ISSUE;
                        end else begin
                            // Illegal command is answered without touching the ALU.
                            rsp_valid <= 1'b1;
                            rsp_id    <= grant_idx;
                            rsp_res   <= '0;
                            {rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err} <= 6'b000001;
                            state_reg <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    alu_inp_valid <= 2'b11;
                    alu_opa       <= opa_reg;
                    alu_opb       <= opb_reg;
                    alu_cmd       <= cmd_reg;
                    alu_mode      <= mode_reg;
                    alu_cin       <= cin_reg;
                    cnt_reg       <= 3'(op_latency(mode_reg, 32'(cmd_reg)));
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_reg;
                        rsp_res   <= res_clean;
                        {rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err} <= flag_clean;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid     <= 1'b0;
                        alu_inp_valid <= 2'b00;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler with a behavioural stand-in for the ALU.
module tb_alu_req_scheduler;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_opa;
    logic [NREQ*DW-1:0] req_opb;
    logic [NREQ*CW-1:0] req_cmd;
    logic [NREQ-1:0]    req_mode;
    logic [NREQ-1:0]    req_cin;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW+1:0]      rsp_res;
    logic               rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err;
    logic               busy, alu_rst, alu_ce;
    logic [1:0]         alu_inp_valid;
    logic [DW-1:0]      alu_opa, alu_opb;
    logic [CW-1:0]      alu_cmd;
    logic               alu_mode, alu_cin;
    logic [DW+1:0]      alu_res;
    logic               alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;

    alu_req_scheduler #(.DW(DW), .CW(CW), .NREQ(NREQ)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_cout(rsp_cout), .rsp_oflow(rsp_oflow),
        .rsp_g(rsp_g), .rsp_e(rsp_e), .rsp_l(rsp_l), .rsp_err(rsp_err),
        .busy(busy), .alu_rst(alu_rst), .alu_ce(alu_ce),
        .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_cmd(alu_cmd), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
        .alu_g(alu_g), .alu_e(alu_e), .alu_l(alu_l), .alu_err(alu_err)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        int         id;
        logic [9:0] res;
        logic       cout, oflow, g, e, l, err;
        int         lat;
        int         hs_edge;
    } exp_t;

    exp_t sb[$];
    int   order_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   stall_left = 0;
    int   first_edge = 0;
    bit   rsp_seen = 0;
    bit   saw_issue = 0;
    logic [31:0] snap;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t ref_op(input int id, input logic mode, input logic [3:0] cmd,
                                    input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t r;
        logic [9:0] aw, bw;
        aw = {2'b00, a};
        bw = {2'b00, b};
        r.id = id; r.res = '0; r.cout = 0; r.oflow = 0; r.g = 0; r.e = 0; r.l = 0;
        r.err = 0; r.lat = 4; r.hs_edge = 0;
        if (mode ? (cmd > 4'd10) : (cmd > 4'd13)) begin
            r.err = 1'b1;
            r.lat = 1;
            return r;
        end
        if (mode && (cmd == 4'd9 || cmd == 4'd10)) r.lat = 5;
        if (mode) begin
            case (cmd)
                4'd0:  begin r.res = aw + bw; r.cout = r.res[8]; end
                4'd1:  begin r.res = aw - bw; r.oflow = (a < b); end
                4'd2:  begin r.res = aw + bw + {9'b0, cin}; r.cout = r.res[8]; end
                4'd3:  begin r.res = aw - bw - {9'b0, cin}; r.oflow = (a < b); end
                4'd8:  begin r.g = (a > b); r.e = (a == b); r.l = (a < b); end
                4'd9:  r.res = (aw + 10'd1) * (bw + 10'd1);
                4'd10: r.res = (aw << 1) * bw;
                default: r.res = '0;
            endcase
        end else begin
            r.res = {2'b00, a & b};
        end
        return r;
    endfunction

    // Stand-in ALU: registers a result on every edge its inputs are valid.
    always @(posedge CLK) begin : alu_model
        exp_t m;
        if (alu_rst) begin
            alu_res <= '0;
            {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err} <= '0;
        end else if (alu_inp_valid == 2'b11) begin
            m = ref_op(0, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin);
            alu_res <= m.res;
            {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err} <= {m.cout, m.oflow, m.g, m.e, m.l, m.err};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    function automatic logic [31:0] pack_rsp();
        return {14'b0, rsp_id, rsp_res, rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err};
    endfunction

    task automatic post(input int c, input logic mode, input logic [3:0] cmd,
                        input logic [7:0] a, input logic [7:0] b, input logic cin);
        req_opa[c*DW +: DW] = a;
        req_opb[c*DW +: DW] = b;
        req_cmd[c*CW +: CW] = cmd;
        req_mode[c]         = mode;
        req_cin[c]          = cin;
        req_valid[c]        = 1'b1;
    endtask

    // One clock: inspect at the falling edge, then advance past the rising edge.
    task automatic step();
        logic [NREQ-1:0] hs_mask;
        exp_t e;
        int   eid;
        hs_mask = '0;
        @(negedge CLK);
        if (rsp_valid && stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
        end else begin
            rsp_ready = 1'b1;
        end
        if (alu_inp_valid == 2'b11) saw_issue = 1'b1;
        if (rsp_valid && !rsp_seen) begin
            rsp_seen   = 1'b1;
            first_edge = cyc + 1;
            snap       = pack_rsp();
        end else if (rsp_valid) begin
            check_val("rsp_stable", pack_rsp(), snap);
            check_val("no_grant_in_resp", 32'(req_ready), 32'(0));
        end
        if (rsp_valid && rsp_ready) begin
            rsp_seen = 1'b0;
            if (sb.size() == 0) begin
                check_val("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check_val("rsp_id", 32'(rsp_id), 32'(e.id));
                check_val("rsp_res", 32'(rsp_res), 32'(e.res));
                check_val("rsp_flags", {26'b0, rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err},
                          {26'b0, e.cout, e.oflow, e.g, e.e, e.l, e.err});
                check_val("rsp_latency", 32'(first_edge - e.hs_edge), 32'(e.lat));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hs_mask[i] = 1'b1;
                eid = (order_q.size() > 0) ? order_q.pop_front() : -1;
                check_val("grant_id", 32'(i), 32'(eid));
                if (eid >= 0) begin
                    e = ref_op(eid, req_mode[eid], req_cmd[eid*CW +: CW],
                               req_opa[eid*DW +: DW], req_opb[eid*DW +: DW], req_cin[eid]);
                    e.hs_edge = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
        @(posedge CLK);
        #1;
        req_valid = req_valid & ~hs_mask;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (req_valid == '0 && sb.size() == 0 && !rsp_valid) done = 1'b1;
            else step();
        end
        if (!done) check_val("drain_timeout", 32'(req_valid) | 32'(sb.size()), 32'(0));
    endtask

    initial begin
        RST = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0; req_opa = '0; req_opb = '0; req_cmd = '0; req_mode = '0; req_cin = '0;
        repeat (2) step();
        @(negedge CLK);
        check_val("rst_req_ready", 32'(req_ready), 32'(0));
        check_val("rst_rsp", {31'b0, rsp_valid} | pack_rsp(), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_alu_ce", 32'(alu_ce), 32'(1));
        check_val("rst_alu_rst", 32'(alu_rst), 32'(1));
        check_val("rst_alu_pins", {8'b0, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}, 32'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single-client operations, including the illegal-command path.
        order_q.push_back(0); post(0, 1'b1, 4'd0, 8'd200, 8'd100, 1'b0); drain();
        order_q.push_back(1); post(1, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);     drain();
        order_q.push_back(2); post(2, 1'b1, 4'd8, 8'd5, 8'd5, 1'b0);     drain();
        saw_issue = 1'b0;
        order_q.push_back(3); post(3, 1'b1, 4'hF, 8'd7, 8'd9, 1'b0);     drain();
        check_val("illegal_no_issue", 32'(saw_issue), 32'(0));

        // Legality boundaries: arithmetic 11 rejected, logical 13 accepted.
        saw_issue = 1'b0;
        order_q.push_back(2); post(2, 1'b1, 4'd11, 8'd1, 8'd1, 1'b0);    drain();
        check_val("arith11_no_issue", 32'(saw_issue), 32'(0));
        order_q.push_back(3); post(3, 1'b0, 4'd13, 8'hF0, 8'h3C, 1'b0);  drain();

        // Contention and response backpressure.
        order_q.push_back(0); order_q.push_back(2);
        stall_left = 3;
        post(0, 1'b1, 4'd0, 8'd10, 8'd20, 1'b0);
        post(2, 1'b1, 4'd1, 8'd50, 8'd8, 1'b0);
        drain();
        order_q.push_back(0); order_q.push_back(1);
        post(0, 1'b1, 4'd2, 8'd255, 8'd1, 1'b1);
        post(1, 1'b1, 4'd10, 8'd6, 8'd7, 1'b0);
        drain();

        // Reset in the middle of an operation drops it.
        order_q.push_back(0); post(0, 1'b1, 4'd0, 8'd1, 8'd2, 1'b0);
        for (int n = 0; n < 10 && alu_inp_valid != 2'b11; n++) step();
        check_val("mid_op_issued", 32'(alu_inp_valid), 32'(3));
        RST = 1'b1;
        step();
        RST = 1'b0;
        sb.delete();
        rsp_seen = 1'b0;
        check_val("post_rst_busy", 32'(busy), 32'(0));
        check_val("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_val("post_rst_inp_valid", 32'(alu_inp_valid), 32'(0));
        repeat (6) step();
        order_q.push_back(1); post(1, 1'b1, 4'd0, 8'd40, 8'd2, 1'b0);    drain();
        check_val("order_q_empty", 32'(order_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
Multi-requester front-end for the shared 8-bit ALU.
- Accepts complete operation requests (OPA, OPB, CMD, MODE, CIN) from NREQ clients.
- Arbitrates among them round-robin, drives the ALU input pins, waits the command-dependent ALU latency and captures RES and the flags.
- Returns one tagged response per request on a single response channel with backpressure.
- Sits between the client blocks and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
- DW, 8, operand width.
- CW, 4, command width.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester ID width (derived, localparam).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-client request valid
- req_ready  out  NREQ  per-client accept; a request transfers when valid&&ready
- req_opa  in  NREQ*DW  flattened operand A, client i at [i*DW +: DW]
- req_opb  in  NREQ*DW  flattened operand B
- req_cmd  in  NREQ*CW  flattened command
- req_mode  in  NREQ  1=arithmetic, 0=logical
- req_cin  in  NREQ  carry-in
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the originating client
- rsp_res  out  DW+2  captured RES
- rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err  out  1 each  captured flags
- busy  out  1  high in every state except IDLE
- alu_rst  out  1  equals RST (combinational pass-through)
- alu_ce  out  1  ALU clock enable
- alu_inp_valid  out  2  ALU INP_VALID
- alu_opa, alu_opb  out  DW each  ALU operands
- alu_cmd  out  CW  ALU command
- alu_mode, alu_cin  out  1 each  ALU mode and carry-in
- alu_res  in  DW+2  ALU RES
- alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err  in  1 each  ALU flags

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_res=0, all rsp flags=0, busy=0, alu_ce=1, alu_inp_valid=2'b00, alu_opa/opb/cmd/mode/cin=0, RR pointer=0, state=IDLE.
- alu_ce is 1 during reset so the ALU clears; it stays 1 at all times.
- FSM states:
  - IDLE: compute the grant.
  - ISSUE: 1 cycle.
  - WAIT: count down.
  - RESP: hold response.
- IDLE:
  - Grant = first i with req_valid[i], scanning from the RR pointer upward and wrapping.
  - req_ready[grant]=1 combinationally for that cycle only (one-hot or zero).
  - On the transfer, latch the request fields and the ID, and set pointer = (grant+1) mod NREQ.
- Legality check on the latched request:
  - MODE=1: legal CMD is 0..10.
  - MODE=0: legal CMD is 0..13.
  - Illegal: skip ISSUE/WAIT and go directly to RESP with rsp_res=0, rsp_err=1, other flags 0. Nothing is driven to the ALU; alu_inp_valid stays 2'b00.
- ISSUE:
  - Drive alu_inp_valid=2'b11 plus the latched operands, command, mode and cin.
  - Hold these values unchanged through WAIT.
  - Load the latency counter: LAT=3 for MODE=1 with CMD 9 or 10, otherwise LAT=2.
  - The counter counts ALU edges from the ISSUE edge, inclusive.
- WAIT:
  - Decrement each cycle.
  - On the cycle the counter reaches 0, sample alu_res and the flags into the rsp registers and go to RESP.
- Flag sampling: a captured flag is 1 only if the ALU pin is logic 1; z or x captures as 0. rsp_res bits that are z or x capture as 0.
- RESP:
  - rsp_valid=1; all rsp fields are stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0, alu_inp_valid=2'b00, go to IDLE.
  - A new grant is not evaluated in the same cycle as the response handshake, so the minimum inter-issue gap is 1 IDLE cycle.
- Total latency from request handshake to rsp_valid, with rsp_ready held high: legal standard op 4 cycles, legal multiply/shift op 5 cycles, illegal op 1 cycle.
- Only one operation is in flight; there is no pipelining.
- RST in any state: same-edge return to IDLE with reset values; the in-flight request is dropped and no response is produced.
- Simultaneous requests: exactly one grant per IDLE cycle; non-granted clients see req_ready=0 and must hold their request.
- RR pointer wraps from NREQ-1 to 0.

Decomposition:
- Shared package alu_sched_pkg contains:
  - The state enum (IDLE, ISSUE, WAIT, RESP).
  - CMD constants ADD=0, SUB=1, ADD_CIN=2, SUB_CIN=3, CMP=8, INC_MUL=9, SHL_SUB=10, ROL=12, ROR=13.
  - MAX_ARITH_CMD=10, MAX_LOGIC_CMD=13.
  - LAT_STD=2, LAT_MUL=3.
- One sub-module, rr_arbiter (NREQ-wide, pointer-based, combinational grant with pointer update on accept), instantiated once.

Test Plan:
1. Client 0: MODE=1, CMD=0, OPA=200, OPB=100 -> rsp_id=0, rsp_res=10'd300, rsp_cout=1, rsp_valid 4 cycles after the handshake.
2. Client 1: MODE=1, CMD=9, OPA=3, OPB=4 -> rsp_res=20 ((3+1)*(4+1)), rsp_valid 5 cycles after the handshake.
3. Client 2: MODE=1, CMD=8, OPA=5, OPB=5 -> rsp_e=1, rsp_g=0, rsp_l=0, rsp_res=0.
4. Client 3: MODE=1, CMD=4'hF -> response 1 cycle later with rsp_err=1, rsp_res=0; alu_inp_valid never equals 2'b11.
5. req_valid=4'b0101 on the same cycle, then 4'b0011 after both complete -> grant order 0, 2, 0, 1. Hold rsp_ready=0 for 3 cycles on the first response -> fields stable, no new grant.
6. Assert RST during WAIT of an ADD -> next cycle busy=0, rsp_valid=0, alu_inp_valid=0; a subsequent request completes normally.
